// File: rtl/dcp_tx_fmt_pkg.sv
// Shared definitions for the DCP transmit formatter:
// state encoding, record lengths and ASCII constants.
package dcp_tx_fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DROP = 2'd2
    } state_e;

    localparam logic [3:0] LEN_RAW = 4'd1;
    localparam logic [3:0] LEN_HEX = 4'd10;

    localparam logic [3:0] IDX_CR = 4'd8;
    localparam logic [3:0] IDX_LF = 4'd9;

    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_UPA  = 8'h41;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;

endpackage

// File: rtl/hex2ascii.sv
// Nibble to uppercase ASCII hex digit, purely combinational.
module hex2ascii
    import dcp_tx_fmt_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] asc_o
);

    always_comb begin
        if (nib_i < 4'd10) begin
            asc_o = ASC_ZERO + {4'd0, nib_i};
        end else begin
            asc_o = ASC_UPA + {4'd0, nib_i} - 8'd10;
        end
    end

endmodule

// File: rtl/dcp_tx_fmt.sv
// Formats command-handler payloads into raw bytes or hex text
// records and streams them to a UART transmitter.
module dcp_tx_fmt
    import dcp_tx_fmt_pkg::*;
#(
    parameter logic [7:0] CHAR_CR = ASC_CR,
    parameter logic [7:0] CHAR_LF = ASC_LF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_tx,
    input  logic        type_tx,
    input  logic [31:0] dout,
    output logic        ack_tx,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        type_q, type_d;
    logic [31:0] data_q, data_d;
    logic        ack_q, ack_d;

    logic [3:0]  nib;
    logic [7:0]  hex_char;
    logic [7:0]  byte_sel;
    logic        last_idx;

    // Hex digits go out most significant nibble first
    always_comb begin
        unique case (idx_q[2:0])
            3'd0: nib = data_q[31:28];
            3'd1: nib = data_q[27:24];
            3'd2: nib = data_q[23:20];
            3'd3: nib = data_q[19:16];
            3'd4: nib = data_q[15:12];
            3'd5: nib = data_q[11:8];
            3'd6: nib = data_q[7:4];
            3'd7: nib = data_q[3:0];
        endcase
    end

    hex2ascii u_hex2ascii (
        .nib_i (nib),
        .asc_o (hex_char)
    );

    always_comb begin
        if (!type_q) begin
            byte_sel = data_q[7:0];
        end else if (idx_q == IDX_CR) begin
            byte_sel = CHAR_CR;
        end else if (idx_q == IDX_LF) begin
            byte_sel = CHAR_LF;
        end else begin
            byte_sel = hex_char;
        end
    end

    assign last_idx = type_q ? (idx_q == LEN_HEX - 4'd1)
                             : (idx_q == LEN_RAW - 4'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        type_d  = type_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_tx) begin
                    state_d = ST_SEND;
                    idx_d   = 4'd0;
                    type_d  = type_tx;
                    data_d  = dout;
                end
            end
            ST_SEND: begin
                if (tx_rdy) begin
                    if (last_idx) begin
                        state_d = ST_WAIT_DROP;
                        idx_d   = 4'd0;
                        ack_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_WAIT_DROP: begin
                // Held request must fall before a new record may start
                if (!req_tx) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            type_q  <= 1'b0;
            data_q  <= 32'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign tx_vld  = (state_q == ST_SEND);
    assign tx_data = tx_vld ? byte_sel : 8'h00;
    assign busy    = (state_q == ST_SEND) || (state_q == ST_WAIT_DROP);
    assign ack_tx  = ack_q;

endmodule

// File: tb/tb_dcp_tx_fmt.sv
// Scoreboard bench for dcp_tx_fmt: directed scenarios plus
// randomized records with random transmitter back-pressure.
module tb_dcp_tx_fmt;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_tx;
    logic        type_tx;
    logic [31:0] dout;
    logic        ack_tx;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int xfer_cnt = 0;
    int ack_cnt  = 0;
    int exp_ack  = 0;

    logic       prev_vld  = 1'b0;
    logic       prev_rdy  = 1'b0;
    logic       prev_ack  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    dcp_tx_fmt dut (
        .clk     (clk),
        .rst     (rst),
        .req_tx  (req_tx),
        .type_tx (type_tx),
        .dout    (dout),
        .ack_tx  (ack_tx),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .busy    (busy)
    );

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Reference record: hex text built from digit arithmetic
    task automatic push_exp(input bit t, input logic [31:0] d);
        int n;
        if (!t) begin
            exp_q.push_back(d[7:0]);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n = int'((d >> (28 - 4 * i)) & 32'hF);
                if (n < 10) exp_q.push_back(8'(48 + n));
                else        exp_q.push_back(8'(65 + n - 10));
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy && tx_vld)
                chk(tx_data == prev_data, "stall_hold", tx_data, prev_data);
            if (tx_vld && tx_rdy) begin
                xfer_cnt++;
                chk(exp_q.size() > 0, "unexpected_byte", tx_data, 0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk(tx_data == e, "byte", tx_data, e);
                end
            end
            if (ack_tx) begin
                ack_cnt++;
                chk(!tx_vld, "ack_with_vld", tx_vld, 0);
                chk(!prev_ack, "ack_width", 2, 1);
                chk(exp_q.size() == 0, "ack_early", exp_q.size(), 0);
            end
            prev_vld  = tx_vld;
            prev_rdy  = tx_rdy;
            prev_ack  = ack_tx;
            prev_data = tx_data;
        end
    end

    // mode: 0 rdy high, 1 random rdy, 2 stall 3 cycles on 4th byte
    task automatic send_rec(input bit t, input logic [31:0] d,
                            input int mode, input int hold,
                            input int chg_at, input int drop_at,
                            input int abort_at);
        int  base;
        int  vcnt;
        int  stall_n;
        int  nbytes;
        bit  got;
        bit  aborted;
        nbytes  = t ? 10 : 1;
        push_exp(t, d);
        exp_ack++;
        base    = xfer_cnt;
        vcnt    = 0;
        stall_n = 0;
        got     = 1'b0;
        aborted = 1'b0;
        @(posedge clk);
        #1;
        req_tx  = 1'b1;
        type_tx = t;
        dout    = d;
        tx_rdy  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int c = 0; c < 300 && !got && !aborted; c++) begin
            @(negedge clk);
            if (tx_vld) vcnt++;
            if (ack_tx) got = 1'b1;
            if (!got) begin
                @(posedge clk);
                #1;
                if (c == chg_at) begin
                    dout    = ~d;
                    type_tx = ~t;
                end
                if (c == drop_at) req_tx = 1'b0;
                if (abort_at > 0 && xfer_cnt - base == abort_at) begin
                    rst     = 1'b1;
                    tx_rdy  = 1'b0;
                    aborted = 1'b1;
                end else begin
                    case (mode)
                        1: tx_rdy = ($urandom_range(0, 3) != 0);
                        2: begin
                            if (xfer_cnt - base == 3 && stall_n < 3) begin
                                tx_rdy = 1'b0;
                                stall_n++;
                            end else begin
                                tx_rdy = 1'b1;
                            end
                        end
                        default: tx_rdy = 1'b1;
                    endcase
                end
            end
        end
        if (aborted) begin
            @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            chk(!tx_vld, "abort_vld", tx_vld, 0);
            chk(!ack_tx, "abort_ack", ack_tx, 0);
            chk(!busy, "abort_busy", busy, 0);
            chk(tx_data == 8'h00, "abort_data", tx_data, 0);
            exp_q.delete();
            exp_ack--;
            @(posedge clk);
            #1;
            rst    = 1'b0;
            req_tx = 1'b0;
            tx_rdy = 1'b1;
            return;
        end
        chk(got, "ack_timeout", got, 1);
        if (mode == 0)
            chk(vcnt == nbytes, "back_to_back", vcnt, nbytes);
        if (mode == 2)
            chk(vcnt == nbytes + 3, "stall_len", vcnt, nbytes + 3);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk(!tx_vld, "no_restart", tx_vld, 0);
            chk(busy, "busy_held", busy, 1);
        end
        @(posedge clk);
        #1;
        req_tx = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(!busy, "busy_drop", busy, 0);
    endtask

    initial begin
        rst     = 1'b1;
        req_tx  = 1'b0;
        type_tx = 1'b0;
        dout    = 32'd0;
        tx_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!tx_vld, "rst_vld", tx_vld, 0);
        chk(!ack_tx, "rst_ack", ack_tx, 0);
        chk(!busy, "rst_busy", busy, 0);
        chk(tx_data == 8'h00, "rst_data", tx_data, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        tx_rdy = 1'b1;

        send_rec(1'b0, 32'h0000_0052, 0, 2, -1, -1, 0);
        send_rec(1'b1, 32'h1234_ABCF, 0, 0, -1, -1, 0);
        send_rec(1'b1, 32'h1234_ABCF, 2, 0, -1, -1, 0);
        send_rec(1'b0, 32'h0000_00A5, 0, 5, -1, -1, 0);
        send_rec(1'b1, 32'hDEAD_BEEF, 0, 0, -1, -1, 5);
        send_rec(1'b1, 32'hDEAD_BEEF, 0, 0, -1, -1, 0);
        send_rec(1'b1, 32'h0000_0000, 0, 0, 2, -1, 0);
        send_rec(1'b1, 32'h89AB_CDEF, 0, 0, -1, 3, 0);

        for (int r = 0; r < 25; r++) begin
            send_rec(1'($urandom_range(0, 1)), $urandom, 1,
                     $urandom_range(0, 3), -1, -1, 0);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk(ack_cnt == exp_ack, "ack_count", ack_cnt, exp_ack);
        chk(exp_q.size() == 0, "bytes_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcp_tx_fmt.md
DCP_TX_FMT -- requirements
Module: dcp_tx_fmt

Interface
REQ-001 SHALL have parameter CHAR_CR, default 8'h0D, meaning the first line-terminator byte of a hex record.
REQ-002 SHALL have parameter CHAR_LF, default 8'h0A, meaning the second line-terminator byte of a hex record.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_tx  input  1  transmit request from a command handler, held high until ack_tx.
REQ-006 SHALL have port type_tx  input  1  record type: 0 = raw byte, 1 = 32-bit hex word.
REQ-007 SHALL have port dout  input  32  payload from the command handler.
REQ-008 SHALL have port ack_tx  output  1  one-cycle completion pulse to the command handler.
REQ-009 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-010 SHALL have port tx_vld  output  1  tx_data valid.
REQ-011 SHALL have port tx_rdy  input  1  UART transmitter can accept a byte.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, SEND, WAIT_DROP.
REQ-014 IDLE with req_tx=1 at edge N: SHALL latch type_tx and dout, clear byte index to 0, and enter SEND; tx_vld SHALL be high from cycle N+1.
REQ-015 Type 0: SHALL send exactly one byte, the latched dout[7:0].
REQ-016 Type 1: SHALL send 10 bytes: 8 uppercase hex ASCII digits, MS nibble first, then CHAR_CR, then CHAR_LF.
REQ-017 Hex mapping: nibble 0-9 -> 8'h30+n; nibble 10-15 -> 8'h41+(n-10).
REQ-018 A byte transfers on a cycle with tx_vld=1 and tx_rdy=1; the byte index SHALL then advance by 1.
REQ-019 tx_data SHALL stay stable while tx_vld=1 and tx_rdy=0, for any number of stall cycles.
REQ-020 Transfers SHALL occur back-to-back when tx_rdy is held high, one byte per cycle, with no bubble.
REQ-021 On the final transfer (index 0 for type 0, index 9 for type 1), SHALL enter WAIT_DROP; ack_tx SHALL be 1 for exactly the next cycle and tx_vld SHALL be 0 in that cycle.
REQ-022 WAIT_DROP SHALL return to IDLE on the first cycle with req_tx=0; a request held high after ack SHALL NOT start a second record.
REQ-023 Changes on dout or type_tx after the IDLE latch SHALL NOT affect the record in progress.
REQ-024 A req_tx drop during SEND SHALL be ignored; the record SHALL complete and be acked.
REQ-025 The byte index SHALL be 4 bits and SHALL never exceed 9; any illegal state SHALL decode to IDLE.

Reset
REQ-026 With rst=1 at a clock edge: state=IDLE, index=0, tx_vld=0, ack_tx=0, tx_data=8'h00, busy=0, and latched payload/type cleared.
REQ-027 Reset mid-record SHALL abort it with no ack_tx, and tx_vld SHALL be 0 in the cycle after the reset edge.

Structure
REQ-028 A shared package SHALL hold the state encoding, the record lengths (1, 10), and the ASCII constants 0x30, 0x41, 0x0D, 0x0A.
REQ-029 The nibble-to-ASCII conversion SHALL be the combinational sub-module hex2ascii (4-bit in, 8-bit out); all other logic stays in dcp_tx_fmt.

Verification
REQ-030 Type 0, dout=32'h00000052, tx_rdy=1 -> single byte 8'h52, then ack_tx one cycle, busy falls after req_tx drops.
REQ-031 Type 1, dout=32'h1234ABCF, tx_rdy=1 -> bytes 31 32 33 34 41 42 43 46 0D 0A on 10 consecutive cycles, then one ack_tx pulse.
REQ-032 Type 1 with tx_rdy=0 for 3 cycles while the 4th byte (0x34) is offered -> tx_data holds 0x34 throughout, no byte lost or duplicated.
REQ-033 req_tx held high 5 cycles past ack_tx -> no new tx_vld until req_tx falls and rises again.
REQ-034 rst asserted after byte 5 of a type-1 record -> tx_vld=0 next cycle, no ack_tx, next request sends a full 10 bytes.
REQ-035 dout changed to 32'hFFFFFFFF during SEND of 32'h00000000 -> output stays 30 x8, 0D, 0A.
